sec_bus_bridge: RTL

Parametrised secondary-bus bridge between the Primary core's secondary port (Addr/Rd/Wr/SecDataRd) and up to 15 user peripheral channels. It decodes a 24-bit address window into per-channel strobes and inserts a fixed number of wait cycles per access. It registers read data back to SecDataRd and, optionally, aggregates per-channel interrupts into the cartridge interrupt request.

---
 rtl/sec_bus_bridge_pkg.sv | 23 ++
 rtl/sec_bus_bridge_if.sv | 28 ++
 rtl/sec_irq_ctrl.sv | 59 +++++
 rtl/sec_bus_bridge.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sec_bus_bridge_pkg.sv
// Shared types and constants for the secondary-bus bridge.
// The control channel and its registers only exist when SEC_BUS_IRQ_EN is defined.
package sec_bus_pkg;

  // Bridge FSM. One access runs IDLE -> ACCESS -> [WAIT] -> DONE -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Channel index of the interrupt control block (Addr[19:16]).
  localparam logic [3:0] CTRL_CH = 4'hF;

  // Control channel register offsets.
  localparam int REG_PEND = 0;
  localparam int REG_EN   = 1;

  // Width of the wait-cycle counter.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/sec_bus_bridge_if.sv
// Primary-side secondary bus of the bridge.
//
// Handshake: a request is the rising edge of Rd or Wr (a level held high is
// not a new request). The bridge raises Busy on the edge after it accepts the
// request and drops it on the edge that makes SecDataRd valid. Rising edges
// seen while Busy is high are discarded, so the master must wait for Busy low
// and produce a fresh edge for the next access. If Rd and Wr rise together the
// access is a write.
interface sec_bus_if #(
  parameter int DATA_W = 16
);
  logic [23:0]       Addr;
  logic              Rd;
  logic              Wr;
  logic [DATA_W-1:0] DataWr;
  logic [DATA_W-1:0] SecDataRd;
  logic              Busy;

  modport master (
    output Addr, Rd, Wr, DataWr,
    input  SecDataRd, Busy
  );

  modport slave (
    input  Addr, Rd, Wr, DataWr,
    output SecDataRd, Busy
  );
endinterface

// File: rtl/sec_irq_ctrl.sv
// Interrupt aggregation for the bridge control channel (SEC_BUS_IRQ_EN builds).
// Rising ChIrq edges set pending bits, writing 1 to the pending register
// clears them (a new edge in the same cycle wins), and IReq is the registered
// OR of pending & enable.
module sec_irq_ctrl
  import sec_bus_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int CH_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    irq,
  input  logic                 wr,
  input  logic [CH_ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 ireq
);

  logic [NUM_CH-1:0] irq_prev;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] irq_rise;
  logic [NUM_CH-1:0] pend_clr;
  logic              sel_pend;
  logic              sel_en;
  logic              unused_wr_data;

  assign sel_pend       = (offset == CH_ADDR_W'(REG_PEND));
  assign sel_en         = (offset == CH_ADDR_W'(REG_EN));
  assign irq_rise       = irq & ~irq_prev;
  assign pend_clr       = (wr && sel_pend) ? wr_data[NUM_CH-1:0] : '0;
  assign unused_wr_data = ^wr_data;

  // Edge history, pending/enable registers and the registered request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      pend     <= '0;
      en       <= '0;
      ireq     <= 1'b0;
    end else begin
      irq_prev <= irq;
      pend     <= (pend & ~pend_clr) | irq_rise;
      if (wr && sel_en) en <= wr_data[NUM_CH-1:0];
      ireq     <= |(pend & en);
    end
  end

  // Register read-back; unused offsets read as zero.
  always_comb begin
    rd_data = '0;
    if (sel_pend)    rd_data = DATA_W'(pend);
    else if (sel_en) rd_data = DATA_W'(en);
  end

endmodule

// File: rtl/sec_bus_bridge.sv
// Secondary-bus bridge: decodes Addr[23:16] into one of NUM_CH peripheral
// channels, strobes it for one cycle, waits WAIT_CYC cycles and registers the
// read data to SecDataRd. Define SEC_BUS_IRQ_EN to add the interrupt control
// channel at index 15 and drive IReq; otherwise IReq is 0 and index 15 is
// unmapped.
module sec_bus_bridge
  import sec_bus_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_CH    = 4,
  parameter int                CH_ADDR_W = 8,
  parameter int                WAIT_CYC  = 2,
  parameter logic [3:0]        BASE      = 4'h8,
  parameter logic [DATA_W-1:0] UNMAPPED  = '1
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  sec_bus_if.slave                 bus,
  output logic [NUM_CH-1:0]        ChRd,
  output logic [NUM_CH-1:0]        ChWr,
  output logic [CH_ADDR_W-1:0]     ChAddr,
  output logic [DATA_W-1:0]        ChDataWr,
  input  logic [NUM_CH*DATA_W-1:0] ChDataRd,
  input  logic [NUM_CH-1:0]        ChIrq,
  output logic                     IReq,
  output state_t                   dbg_state
);

  state_t              state;
  state_t              state_n;
  logic [WAIT_W-1:0]   cnt;
  logic [WAIT_W-1:0]   cnt_n;

  logic                rd_prev;
  logic                wr_prev;
  logic                req_wr;
  logic                req_rd;
  logic                accept;

  logic [3:0]          idx;
  logic                base_hit;
  logic                dec_map;
  logic                dec_ctrl;
  logic [NUM_CH-1:0]   dec_onehot;

  logic                lat_wr;
  logic                lat_map;
  logic                lat_ctrl;
  logic [3:0]          lat_idx;

  logic [DATA_W-1:0]   rd_sel;
  logic [DATA_W-1:0]   ctrl_rd_data;
  logic                ctrl_wr;
  logic                unused_addr;

  // Request detection: write wins over a simultaneous read edge.
  assign req_wr      = bus.Wr & ~wr_prev;
  assign req_rd      = bus.Rd & ~rd_prev & ~req_wr;
  assign accept      = (state == ST_IDLE) && (req_wr || req_rd);

  // Live decode, latched on accept.
  assign idx         = bus.Addr[19:16];
  assign base_hit    = (bus.Addr[23:20] == BASE);
  assign dec_map     = base_hit && (int'(idx) < NUM_CH);
  assign dec_onehot  = NUM_CH'(1) << idx;
  assign unused_addr = ^bus.Addr[15:0];
  assign dbg_state   = state;

  // Control channel writes take effect in the ACCESS cycle.
  assign ctrl_wr     = (state == ST_ACCESS) && lat_wr && lat_ctrl;

`ifdef SEC_BUS_IRQ_EN
  assign dec_ctrl = base_hit && (idx == CTRL_CH);

  sec_irq_ctrl #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .CH_ADDR_W (CH_ADDR_W)
  ) u_irq_ctrl (
    .clk     (Clk),
    .rst_n   (ResetN),
    .irq     (ChIrq),
    .wr      (ctrl_wr),
    .offset  (ChAddr),
    .wr_data (ChDataWr),
    .rd_data (ctrl_rd_data),
    .ireq    (IReq)
  );
`else
  logic unused_irq;
  assign dec_ctrl     = 1'b0;
  assign ctrl_rd_data = '0;
  assign IReq         = 1'b0;
  assign unused_irq   = ^{ChIrq, ctrl_wr};
`endif

  // Read data of the latched channel.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lat_idx == 4'(i)) rd_sel = ChDataRd[i*DATA_W +: DATA_W];
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // FSM next state; the control channel skips the wait phase.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_n = '0;
        if (WAIT_CYC == 0 || lat_ctrl) state_n = ST_DONE;
        else                           state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == WAIT_W'(WAIT_CYC - 1)) state_n = ST_DONE;
        else                              cnt_n   = cnt + 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Edge history, request latches, registered strobes, Busy and read data.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      rd_prev       <= 1'b0;
      wr_prev       <= 1'b0;
      lat_wr        <= 1'b0;
      lat_map       <= 1'b0;
      lat_ctrl      <= 1'b0;
      lat_idx       <= '0;
      ChAddr        <= '0;
      ChDataWr      <= '0;
      ChRd          <= '0;
      ChWr          <= '0;
      bus.Busy      <= 1'b0;
      bus.SecDataRd <= '0;
    end else begin
      rd_prev  <= bus.Rd;
      wr_prev  <= bus.Wr;
      bus.Busy <= (state_n != ST_IDLE);
      ChRd     <= '0;
      ChWr     <= '0;
      if (accept) begin
        lat_wr   <= req_wr;
        lat_map  <= dec_map;
        lat_ctrl <= dec_ctrl;
        lat_idx  <= idx;
        ChAddr   <= bus.Addr[CH_ADDR_W-1:0];
        ChDataWr <= bus.DataWr;
        if (dec_map) begin
          if (req_wr) ChWr <= dec_onehot;
          else        ChRd <= dec_onehot;
        end
      end
      if (state == ST_DONE && !lat_wr) begin
        if (lat_ctrl)     bus.SecDataRd <= ctrl_rd_data;
        else if (lat_map) bus.SecDataRd <= rd_sel;
        else              bus.SecDataRd <= UNMAPPED;
      end
    end
  end

endmodule
